// File: rtl/gauss3x3_stream.sv
// Streaming 3x3 Gaussian blur ([1 2 1; 2 4 2; 1 2 1]/16, rounded) over a raster pixel stream.
// Two line buffers feed a 3x3 window; only interior pixels produce output.
`timescale 1ns/1ps
module gauss3x3_stream #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic [7:0]    pix_in,
  output logic [7:0]    pix_out,
  output logic          out_valid,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          frame_done
);

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic          win_complete;

  assign col_last     = (col == XW'(WIDTH - 1));
  assign row_last     = (row == YW'(HEIGHT - 1));
  assign win_complete = pix_valid && (col >= XW'(2)) && (row >= YW'(2));

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample the pre-edge values and the pipeline shifts by exactly one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + YW'(1);
      end else begin
        col <= col + XW'(1);
      end
    end
  end

  // lb1 holds the previous line, lb2 the line before it; both indexed by column.
  logic [7:0] lb1 [WIDTH];
  logic [7:0] lb2 [WIDTH];
  logic [7:0] lb1_rd;
  logic [7:0] lb2_rd;

  assign lb1_rd = lb1[col];
  assign lb2_rd = lb2[col];

  // NOTE: the line-buffer RAM has no reset; stale contents are harmless because
  // no window is marked complete until two fresh lines have been written.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2[col] <= lb1_rd;
      lb1[col] <= pix_in;
    end
  end

  // win[c][r]: c = 0 oldest column .. 2 newest, r = 0 top (row-2) .. 2 bottom (row).
  logic [7:0]    win [3][3];
  logic          w_valid;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          win[c][r] <= '0;
        end
      end
      w_valid <= 1'b0;
      w_x     <= '0;
      w_y     <= '0;
      w_last  <= 1'b0;
    end else begin
      w_valid <= win_complete;
      if (pix_valid) begin
        win[0]    <= win[1];
        win[1]    <= win[2];
        win[2][0] <= lb2_rd;
        win[2][1] <= lb1_rd;
        win[2][2] <= pix_in;
        w_x       <= col - XW'(1);
        w_y       <= row - YW'(1);
        w_last    <= col_last && row_last;
      end
    end
  end

  // Weighted sum peaks at 16*255 = 4080, so 12 bits never overflow.
  logic [11:0] sum_c;

  assign sum_c = 12'(win[0][0]) + 12'(win[2][0]) + 12'(win[0][2]) + 12'(win[2][2])
               + ((12'(win[1][0]) + 12'(win[0][1]) + 12'(win[2][1]) + 12'(win[1][2])) << 1)
               + (12'(win[1][1]) << 2);

  logic [11:0]   s1_sum;
  logic          s1_valid;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic          s1_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sum   <= '0;
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_sum   <= sum_c;
      s1_valid <= w_valid;
      s1_x     <= w_x;
      s1_y     <= w_y;
      s1_last  <= w_last;
    end
  end

  // Rounded divide by 16; 4080 + 8 still fits 12 bits and the result fits 8.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out    <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_out    <= 8'((s1_sum + 12'd8) >> 4);
      out_valid  <= s1_valid;
      out_x      <= s1_x;
      out_y      <= s1_y;
      frame_done <= s1_valid && s1_last;
    end
  end

endmodule

// File: tb/tb_gauss3x3_stream.sv
// Scoreboard bench for gauss3x3_stream: three instances (128x128, 20x14, 4x4) driven with
// image patterns; a 2-D reference model predicts every output, a monitor checks them.
`timescale 1ns/1ps
module tb_gauss3x3_stream;

  typedef struct {
    int     id;
    int     pix;
    int     x;
    int     y;
    int     done;
    longint t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] pv  = '0;
  logic [7:0] pin [3];

  logic [7:0] po_a, po_b, po_c;
  logic       ov_a, ov_b, ov_c;
  logic       fd_a, fd_b, fd_c;
  logic [6:0] ox_a, oy_a;
  logic [4:0] ox_b;
  logic [3:0] oy_b;
  logic [1:0] ox_c, oy_c;

  gauss3x3_stream #(.WIDTH(128), .HEIGHT(128)) u_a (
    .clk(clk), .rst(rst), .pix_valid(pv[0]), .pix_in(pin[0]), .pix_out(po_a),
    .out_valid(ov_a), .out_x(ox_a), .out_y(oy_a), .frame_done(fd_a));

  gauss3x3_stream #(.WIDTH(20), .HEIGHT(14)) u_b (
    .clk(clk), .rst(rst), .pix_valid(pv[1]), .pix_in(pin[1]), .pix_out(po_b),
    .out_valid(ov_b), .out_x(ox_b), .out_y(oy_b), .frame_done(fd_b));

  gauss3x3_stream #(.WIDTH(4), .HEIGHT(4)) u_c (
    .clk(clk), .rst(rst), .pix_valid(pv[2]), .pix_in(pin[2]), .pix_out(po_c),
    .out_valid(ov_c), .out_x(ox_c), .out_y(oy_c), .frame_done(fd_c));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   out_cnt  = 0;
  int   done_cnt = 0;
  int   img [0:127][0:127];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Field layout: id | pix | x | y | done | cycle, nibble aligned for readable hex.
  function automatic longint pack(input int id, input int pix, input int x, input int y,
                                  input int done, input longint t);
    return (longint'(id) << 52) | (longint'(pix) << 44) | (longint'(x) << 36) |
           (longint'(y) << 28) | (longint'(done) << 24) | (t & 64'hFF_FFFF);
  endfunction

  // Gaussian weight for offset (dx,dy) is (2-|dx|)*(2-|dy|): 4 centre, 2 edge, 1 corner.
  function automatic int model(input int x, input int y);
    int s = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        s += (2 - (dx < 0 ? -dx : dx)) * (2 - (dy < 0 ? -dy : dy)) * img[y + dy][x + dx];
      end
    end
    return (s + 8) / 16;
  endfunction

  task automatic mon(input int id, input logic v, input int p, input int x, input int y,
                     input int fd);
    exp_t e;
    if (fd != 0) done_cnt++;
    if (v) begin
      out_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected output dut%0d: got pix=%0d at (%0d,%0d) cycle %0d, required none",
                 id, p, x, y, cyc);
      end else begin
        e = sb.pop_front();
        check($sformatf("out dut%0d centre (%0d,%0d)", e.id, e.x, e.y),
              pack(id, p, x, y, fd, cyc), pack(e.id, e.pix, e.x, e.y, e.done, e.t));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov_a, int'(po_a), int'(ox_a), int'(oy_a), int'(fd_a));
    mon(1, ov_b, int'(po_b), int'(ox_b), int'(oy_b), int'(fd_b));
    mon(2, ov_c, int'(po_c), int'(ox_c), int'(oy_c), int'(fd_c));
  end

  // mode: 0 const 100, 1 impulse 255 at (10,10), 2 ramp=col, 3 random, 4 raster counter.
  // Stops before pixel (stop_r,stop_c) when that position is reached.
  task automatic run_frame(input int id, input int w, input int h, input int mode,
                           input int gap, input int stop_r, input int stop_c);
    out_cnt  = 0;
    done_cnt = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        case (mode)
          0:       img[y][x] = 100;
          1:       img[y][x] = (x == 10 && y == 10) ? 255 : 0;
          2:       img[y][x] = x;
          3:       img[y][x] = int'($urandom_range(0, 255));
          default: img[y][x] = (y * w + x) & 255;
        endcase
      end
    end
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (y == stop_r && x == stop_c) return;
        @(negedge clk);
        pv[id] = 1'b0;
        while (gap > 0 && int'($urandom_range(0, 99)) < gap) @(negedge clk);
        pv[id]  = 1'b1;
        pin[id] = 8'(img[y][x]);
        // Accepted at the next edge (cyc+1); output visible after edge cyc+3.
        if (x >= 2 && y >= 2)
          sb.push_back('{id, model(x - 1, y - 1), x - 1, y - 1,
                         int'(x == w - 1 && y == h - 1), cyc + 3});
      end
    end
    @(negedge clk);
    pv[id] = 1'b0;
    repeat (6) @(negedge clk);
    check($sformatf("drain dut%0d mode%0d", id, mode), longint'(sb.size()), 0);
    check($sformatf("count dut%0d mode%0d", id, mode), longint'(out_cnt),
          longint'((w - 2) * (h - 2)));
    check($sformatf("frame_done dut%0d mode%0d", id, mode), longint'(done_cnt), 1);
  endtask

  initial begin
    pin[0] = '0;
    pin[1] = '0;
    pin[2] = '0;
    #1 rst = 1'b1;
    #2;
    check("reset dut0", longint'({po_a, ov_a, ox_a, oy_a, fd_a}), 0);
    check("reset dut1", longint'({po_b, ov_b, ox_b, oy_b, fd_b}), 0);
    check("reset dut2", longint'({po_c, ov_c, ox_c, oy_c, fd_c}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_frame(2, 4, 4, 4, 0, -1, -1);
    run_frame(1, 20, 14, 1, 0, -1, -1);
    run_frame(1, 20, 14, 2, 0, -1, -1);
    run_frame(1, 20, 14, 3, 30, -1, -1);
    run_frame(1, 20, 14, 0, 30, -1, -1);
    run_frame(2, 4, 4, 3, 30, -1, -1);
    run_frame(0, 128, 128, 0, 0, -1, -1);
    run_frame(0, 128, 128, 2, 0, -1, -1);

    // Reset in the middle of row 5 with outputs still in flight.
    run_frame(0, 128, 128, 3, 0, 5, 60);
    @(posedge clk);
    #2;
    rst    = 1'b1;
    pv[0]  = 1'b0;
    sb.delete();
    #1;
    check("mid-frame reset outputs", longint'({po_a, ov_a, ox_a, oy_a, fd_a}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_frame(0, 128, 128, 3, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
